mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide controller for the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the E stage and owns the HI/LO registers. It models fixed operation latency with a busy counter and raises a stall request whenever the D-stage instruction needs the unit while an operation is still in flight.

---
 rtl/mdu_pkg.sv | 51 +++++
 rtl/mdu_arith.sv | 76 +++++++
 rtl/mdu_ctrl.sv | 125 ++++++++++++
 tb/tb_mdu_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op encodings (mdu_op_e) and classification helpers
//   - default latency constants and busy-counter width
//   - hilo_t payload for a {HI, LO} pair
// Optional feature macro: MDU_MADD_EN (accepts MADD/MADDU as arithmetic ops).
package mdu_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MADDU = 3'd7
    } mdu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Ops that occupy the unit for a multi-cycle latency.
    function automatic logic is_arith(input logic [2:0] op);
        logic r;
        r = 1'b0;
        case (mdu_op_e'(op))
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
            OP_MADD, OP_MADDU:                  r = MADD_EN;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (mdu_op_e'(op) == OP_DIV) || (mdu_op_e'(op) == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational datapath for the multiply/divide unit.
// Ports:
//   op      in  3   operation code (mdu_op_e)
//   rs_val  in  32  rs operand
//   rt_val  in  32  rt operand
//   hi, lo  in  32  current HI/LO (accumulator for MADD/MADDU)
//   result  out 64  {hi, lo} produced by the op
//   div0    out 1   DIV/DIVU with a zero divisor
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output hilo_t           result,
    output logic            div0
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_u;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   quo_u;
    logic [XLEN-1:0]   rem_u;
    logic              rt_zero;

    assign rt_zero = (rt_val == '0);

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    always_comb begin
        prod_s = {{XLEN{rs_val[XLEN-1]}}, rs_val} * {{XLEN{rt_val[XLEN-1]}}, rt_val};
        prod_u = {{XLEN{1'b0}}, rs_val} * {{XLEN{1'b0}}, rt_val};
        acc    = {hi, lo};
    end

    // Zero divisor and INT_MIN/-1 are steered away from the divider.
    always_comb begin
        quo_s = '0;
        rem_s = '0;
        quo_u = '0;
        rem_u = '0;
        if (!rt_zero) begin
            quo_u = rs_val / rt_val;
            rem_u = rs_val % rt_val;
            if ((rs_val == INT_MIN) && (rt_val == '1)) begin
                quo_s = INT_MIN;
                rem_s = '0;
            end else begin
                quo_s = XLEN'($signed(rs_val) / $signed(rt_val));
                rem_s = XLEN'($signed(rs_val) % $signed(rt_val));
            end
        end
    end

    // Result select.
    always_comb begin
        result = acc;
        case (mdu_op_e'(op))
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {rem_s, quo_s};
            OP_DIVU:  result = {rem_u, quo_u};
            OP_MADD:  result = acc + prod_s;
            OP_MADDU: result = acc + prod_u;
            default:  result = acc;
        endcase
    end

    assign div0 = is_div(op) && rt_zero;

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller owning HI/LO.
// Parameters: MULT_CYCLES (1..15), DIV_CYCLES (1..15).
// Ports:
//   clk       in  1   pipeline clock, rising edge
//   reset     in  1   asynchronous active-low reset
//   start     in  1   E-stage MDU op this cycle
//   op        in  3   operation code (mdu_op_e)
//   rs_val    in  32  forwarded rs operand
//   rt_val    in  32  forwarded rt operand
//   d_md_use  in  1   D-stage instruction uses the MDU or HI/LO
//   busy      out 1   operation in flight
//   stall     out 1   freeze F/D (combinational from inputs and counter state)
//   hi, lo    out 32  architectural HI/LO
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate into HI/LO).
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            d_md_use,
    output logic            busy,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    hilo_t           pend_q, pend_d;
    logic            pend_div0_q, pend_div0_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    hilo_t           arith_res;
    logic            arith_div0;
    logic            start_arith;

    mdu_arith u_arith (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (arith_res),
        .div0   (arith_div0)
    );

    assign start_arith = start & is_arith(op);

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_div0_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_div0_q <= pend_div0_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    // Next state: launch in IDLE, count down in RUN, commit on the last edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_div0_d = pend_div0_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_arith) begin
                    pend_d      = arith_res;
                    pend_div0_d = arith_div0;
                    cnt_d       = is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d     = ST_RUN;
                end else if (start && (mdu_op_e'(op) == OP_MTHI)) begin
                    hi_d = rs_val;
                end else if (start && (mdu_op_e'(op) == OP_MTLO)) begin
                    lo_d = rs_val;
                end
            end
            ST_RUN: begin
                // New starts are ignored while an op is in flight.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (!pend_div0_q) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy  = (state_q == ST_RUN);
    assign stall = d_md_use & (busy | start_arith);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed plus randomized checks of mdu_ctrl against a
// plain-arithmetic model of HI/LO and operation latency.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int unsigned TB_MULT = 5;
    localparam int unsigned TB_DIV  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(.MULT_CYCLES(TB_MULT), .DIV_CYCLES(TB_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_md_use (d_md_use),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_madd_on();
`ifdef MDU_MADD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int ref_latency(input logic [2:0] o);
        if (o == 3'd0 || o == 3'd1) return int'(TB_MULT);
        if (o == 3'd2 || o == 3'd3) return int'(TB_DIV);
        if ((o == 3'd6 || o == 3'd7) && ref_madd_on()) return int'(TB_MULT);
        return 0;
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Division by magnitudes, then signs fixed up: quotient toward zero,
    // remainder follows the dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        bit na;
        bit nb;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? (32'd0 - a) : a;
        mb = nb ? (32'd0 - b) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (na ^ nb) q = 32'd0 - q;
        if (na) r = 32'd0 - r;
        return {r, q};
    endfunction

    function automatic logic [63:0] ref_exec(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
        case (o)
            3'd0: return ref_mul(a, b, 1'b1);
            3'd1: return ref_mul(a, b, 1'b0);
            3'd2: return (b == 0) ? {h, l} : ref_div(a, b, 1'b1);
            3'd3: return (b == 0) ? {h, l} : ref_div(a, b, 1'b0);
            3'd4: return {a, l};
            3'd5: return {h, a};
            3'd6: return ref_madd_on() ? ({h, l} + ref_mul(a, b, 1'b1)) : {h, l};
            default: return ref_madd_on() ? ({h, l} + ref_mul(a, b, 1'b0)) : {h, l};
        endcase
    endfunction

    // Issue one op, check stall on the start cycle, busy/stall/hold over the
    // latency window, then the committed HI/LO once busy drops.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, input bit inject_mt);
        logic [63:0] nxt;
        int n;
        n   = ref_latency(o);
        nxt = ref_exec(o, a, b, m_hi, m_lo);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b; d_md_use = use_d;
        #1;
        chk("stall_start", {63'd0, stall}, {63'd0, use_d & (n != 0)});
        @(negedge clk);
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
        for (int i = 1; i <= n; i++) begin
            chk("busy_run", {63'd0, busy}, 64'd1);
            chk("stall_run", {63'd0, stall}, {63'd0, use_d});
            chk("hilo_hold", {hi, lo}, {m_hi, m_lo});
            if (inject_mt && i == 2) begin
                start = 1'b1; op = 3'd5; rs_val = 32'h1234;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        {m_hi, m_lo} = nxt;
        chk("busy_done", {63'd0, busy}, 64'd0);
        chk("stall_done", {63'd0, stall}, 64'd0);
        chk("hilo_done", {hi, lo}, nxt);
        d_md_use = 1'b0;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0; errors = 0;
        m_hi = 32'd0; m_lo = 32'd0;
        start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; d_md_use = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed cases.
        do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        chk("multu_mtlo_ignored", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd4, 32'h0000_00AA, 32'd0, 1'b0, 1'b0);
        do_op(3'd5, 32'h0000_00BB, 32'd0, 1'b0, 1'b0);
        chk("mthi_mtlo", {hi, lo}, 64'h0000_00AA_0000_00BB);
        do_op(3'd3, 32'd7, 32'd0, 1'b1, 1'b0);
        chk("divu_by_zero", {hi, lo}, 64'h0000_00AA_0000_00BB);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

`ifdef MDU_MADD_EN
        do_op(3'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        do_op(3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        do_op(3'd7, 32'd1, 32'd1, 1'b1, 1'b0);
        chk("maddu_carry", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        do_op(3'd6, 32'd3, 32'd4, 1'b1, 1'b0);
        chk("madd_noop", {hi, lo}, {m_hi, m_lo});
`endif

        // Reset in the middle of an operation discards it.
        do_op(3'd4, 32'h55, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midop_rst_busy", {63'd0, busy}, 64'd0);
        chk("midop_rst_hilo", {hi, lo}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_hilo", {hi, lo}, 64'd0);

        // Randomized ops against the model.
        for (int k = 0; k < 30; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 4) == 0) rb = 32'd0;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 20)) - 32'd10;
            do_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
